// File: rtl/ocx_tlx_vcn_fifo_ctl_pkg.sv
// Shared definitions for the multi-pool TLX receive FIFO controller:
// credit-return encoding, pool-tag width helper and pointer update decode.
package ocx_tlx_vcn_fifo_ctl_pkg;

  // Each pool can return 0..3 credits per cycle.
  localparam int unsigned CRET_W = 2;

  // Tag width needed to name NUM_POOLS pools; never narrower than one bit.
  function automatic int unsigned pool_w_f(input int unsigned num_pools);
    return (num_pools <= 1) ? 1 : $clog2(num_pools);
  endfunction

  typedef enum logic [1:0] {
    PTR_HOLD     = 2'd0,
    PTR_COMMIT   = 2'd1,
    PTR_ROLLBACK = 2'd2
  } ptr_op_e;

  // Rollback has priority: a CRC error voids the commit of the same cycle.
  function automatic ptr_op_e ptr_op_f(input logic commit, input logic rollback);
    if (rollback) return PTR_ROLLBACK;
    if (commit)   return PTR_COMMIT;
    return PTR_HOLD;
  endfunction

endpackage

// File: rtl/ocx_tlx_vcn_fifo_ctl_credit_pool_cnt.sv
// Single saturating credit counter: level load, 0..3 returns, 1-credit consume.
module ocx_tlx_credit_pool_cnt
  import ocx_tlx_vcn_fifo_ctl_pkg::*;
#(
  parameter int unsigned CW = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [CW-1:0]     init,
  input  logic [CRET_W-1:0] ret,
  input  logic              dec,
  output logic [CW-1:0]     cnt,
  output logic              sat_c
);

  localparam int unsigned SUM_W = CW + 2;
  localparam logic [SUM_W-1:0] CNT_MAX = {2'b00, {CW{1'b1}}};

  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [SUM_W-1:0] sum;

  always_comb begin
    cnt_d = cnt_q;
    sat_c = 1'b0;
    sum   = SUM_W'(cnt_q) + SUM_W'(ret) - SUM_W'(dec);
    if (load) begin
      cnt_d = init;
    end else if (sum > CNT_MAX) begin
      cnt_d = CNT_MAX[CW-1:0];
      sat_c = 1'b1;
    end else begin
      cnt_d = sum[CW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ocx_tlx_vcn_fifo_ctl.sv
// Receive FIFO pointer controller with CRC commit/rollback speculation and
// per-pool credit gating of reads toward the TLX-to-AFU arbiter.
module ocx_tlx_vcn_fifo_ctl
  import ocx_tlx_vcn_fifo_ctl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH   = 56,
  parameter int unsigned NUM_POOLS    = 2,
  parameter int unsigned POOL_W       = 1,
  parameter int unsigned CREDIT_WIDTH = 7
) (
  input  logic                           tlx_clk,
  input  logic                           reset,
  input  logic                           fp_rcv_valid,
  input  logic [DATA_WIDTH-1:0]          fp_rcv_info,
  input  logic [POOL_W-1:0]              fp_rcv_pool,
  input  logic                           commit,
  input  logic                           rollback,
  input  logic                           credit_load,
  input  logic [NUM_POOLS*CREDIT_WIDTH-1:0] init_credit,
  input  logic [NUM_POOLS*CRET_W-1:0]    credit_return,
  input  logic [NUM_POOLS-1:0]           pool_enable,
  input  logic                           rd_stall,
  output logic                           wr_ena,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic [DATA_WIDTH-1:0]          wr_data,
  output logic                           rd_ena,
  output logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic [POOL_W-1:0]              rd_pool,
  output logic [ADDR_WIDTH:0]            fifo_level,
  output logic                           fifo_full,
  output logic                           overflow_err,
  output logic                           credit_err
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]  verif_ptr_q, verif_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
  logic [POOL_W-1:0] tag_q [DEPTH];
  logic [POOL_W-1:0] tag_d [DEPTH];
  logic              overflow_err_q, overflow_err_d;
  logic              credit_err_q,   credit_err_d;

  logic [PTR_W-1:0]        wr_ptr_inc;
  logic                    full_c;
  logic                    empty_c;
  logic                    wr_ena_c;
  logic                    rd_ena_c;
  logic                    pool_ok_c;
  logic [POOL_W-1:0]       head_tag;
  logic [NUM_POOLS-1:0]    dec_c;
  logic [NUM_POOLS-1:0]    sat_c;
  logic [CREDIT_WIDTH-1:0] credit_cnt [NUM_POOLS];
  ptr_op_e                 ptr_op;

  // Full when the wrap bits differ and the index bits match.
  assign full_c   = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                    (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign empty_c  = (verif_ptr_q == rd_ptr_q);
  assign head_tag = tag_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign wr_ena_c = fp_rcv_valid & ~full_c;
  assign ptr_op   = ptr_op_f(commit, rollback);

  // Head entry is readable if its pool is bypassed or holds a credit.
  always_comb begin
    pool_ok_c = 1'b1;
    for (int p = 0; p < NUM_POOLS; p++) begin
      if (head_tag == POOL_W'(p)) begin
        pool_ok_c = ~pool_enable[p] | (credit_cnt[p] != '0);
      end
    end
  end

  assign rd_ena_c = ~empty_c & ~rd_stall & ~credit_load & pool_ok_c;

  always_comb begin
    wr_ptr_inc     = wr_ptr_q + PTR_W'(wr_ena_c);
    wr_ptr_d       = wr_ptr_inc;
    verif_ptr_d    = verif_ptr_q;
    rd_ptr_d       = rd_ptr_q + PTR_W'(rd_ena_c);
    tag_d          = tag_q;
    overflow_err_d = overflow_err_q | (fp_rcv_valid & full_c);
    credit_err_d   = credit_err_q | (|sat_c);
    if (wr_ena_c) tag_d[wr_ptr_q[ADDR_WIDTH-1:0]] = fp_rcv_pool;
    case (ptr_op)
      PTR_ROLLBACK: wr_ptr_d    = verif_ptr_q;
      PTR_COMMIT:   verif_ptr_d = wr_ptr_inc;
      default:      ;
    endcase
  end

  always_ff @(posedge tlx_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      verif_ptr_q    <= '0;
      rd_ptr_q       <= '0;
      overflow_err_q <= 1'b0;
      credit_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      verif_ptr_q    <= verif_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      overflow_err_q <= overflow_err_d;
      credit_err_q   <= credit_err_d;
      tag_q          <= tag_d;
    end
  end

  // Only credit-checked pools are charged for a read.
  always_comb begin
    dec_c = '0;
    for (int p = 0; p < NUM_POOLS; p++) begin
      dec_c[p] = rd_ena_c & (head_tag == POOL_W'(p)) & pool_enable[p];
    end
  end

  for (genvar p = 0; p < NUM_POOLS; p++) begin : g_pool
    ocx_tlx_credit_pool_cnt #(
      .CW (CREDIT_WIDTH)
    ) u_cnt (
      .clk   (tlx_clk),
      .rst   (reset),
      .load  (credit_load),
      .init  (init_credit[p*CREDIT_WIDTH +: CREDIT_WIDTH]),
      .ret   (credit_return[p*CRET_W +: CRET_W]),
      .dec   (dec_c[p]),
      .cnt   (credit_cnt[p]),
      .sat_c (sat_c[p])
    );
  end

  assign wr_ena       = wr_ena_c;
  assign wr_addr      = wr_ptr_q[ADDR_WIDTH-1:0];
  assign wr_data      = fp_rcv_info;
  assign rd_ena       = rd_ena_c;
  assign rd_addr      = rd_ptr_q[ADDR_WIDTH-1:0];
  assign rd_pool      = head_tag;
  assign fifo_level   = wr_ptr_q - rd_ptr_q;
  assign fifo_full    = full_c;
  assign overflow_err = overflow_err_q;
  assign credit_err   = credit_err_q;

endmodule
